// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: MM:SS BCD counter with run/pause/adjust modes,
// a four-digit multiplexed display scan and an adjust-mode blink that
// blanks the digits of the field being edited.
module stopwatch_ctrl #(
    parameter int unsigned MAX_MIN = 59
) (
    input  logic       sclk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       tick_400hz,
    input  logic       btn_pause,
    input  logic       btn_clr,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] digit_idx,
    output logic [3:0] digit_val,
    output logic       digit_blank,
    output logic       running,
    output logic       wrap
);

    typedef enum logic [1:0] {
        PAUSED = 2'd0,
        RUN    = 2'd1,
        ADJUST = 2'd2
    } state_t;

    // Upper limits of each field, held in the same BCD form as the count
    localparam logic [7:0] MIN_LIMIT = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
    localparam logic [7:0] SEC_LIMIT = 8'h59;

    state_t     state_r;
    state_t     state_s;
    logic [7:0] min_r;
    logic [7:0] min_s;
    logic [7:0] sec_r;
    logic [7:0] sec_s;
    logic [1:0] idx_r;
    logic [1:0] idx_s;
    logic       blink_r;
    logic       blink_s;
    logic       wrap_r;
    logic       wrap_s;

    // Two-digit BCD increment that rolls to 00 once the limit is reached,
    // so digits never leave their legal range
    function automatic logic [7:0] bcd_inc(input logic [7:0] value, input logic [7:0] limit);
        logic [7:0] result;
        if (value == limit) begin
            result = 8'h00;
        end else if (value[3:0] == 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
        return result;
    endfunction

    // Next-state logic: the adjust switch outranks the pause button
    always_comb begin
        state_s = state_r;
        case (state_r)
            PAUSED: begin
                if (sw_adj) begin
                    state_s = ADJUST;
                end else if (btn_pause) begin
                    state_s = RUN;
                end else begin
                    state_s = PAUSED;
                end
            end
            RUN: begin
                if (sw_adj) begin
                    state_s = ADJUST;
                end else if (btn_pause) begin
                    state_s = PAUSED;
                end else begin
                    state_s = RUN;
                end
            end
            ADJUST: begin
                if (!sw_adj) begin
                    state_s = PAUSED;
                end else begin
                    state_s = ADJUST;
                end
            end
            default: state_s = PAUSED;
        endcase
    end

    // Count update: clear wins over any tick; run ticks carry, adjust ticks do not
    always_comb begin
        min_s  = min_r;
        sec_s  = sec_r;
        wrap_s = 1'b0;
        if (btn_clr) begin
            min_s = 8'h00;
            sec_s = 8'h00;
        end else if ((state_r == RUN) && tick_1hz) begin
            if (sec_r == SEC_LIMIT) begin
                sec_s  = 8'h00;
                min_s  = bcd_inc(min_r, MIN_LIMIT);
                wrap_s = (min_r == MIN_LIMIT);
            end else begin
                sec_s = bcd_inc(sec_r, SEC_LIMIT);
            end
        end else if ((state_r == ADJUST) && tick_2hz) begin
            if (sw_sel) begin
                sec_s = bcd_inc(sec_r, SEC_LIMIT);
            end else begin
                min_s = bcd_inc(min_r, MIN_LIMIT);
            end
        end else begin
            min_s = min_r;
            sec_s = sec_r;
        end
    end

    // Blink phase toggles only while staying in adjust; cleared on leaving it
    always_comb begin
        blink_s = 1'b0;
        if ((state_r == ADJUST) && (state_s == ADJUST)) begin
            if (tick_2hz) begin
                blink_s = ~blink_r;
            end else begin
                blink_s = blink_r;
            end
        end else begin
            blink_s = 1'b0;
        end
    end

    // Display scan pointer steps once per scan tick
    always_comb begin
        idx_s = idx_r;
        if (tick_400hz) begin
            idx_s = idx_r + 2'd1;
        end else begin
            idx_s = idx_r;
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= PAUSED;
            min_r   <= 8'h00;
            sec_r   <= 8'h00;
            idx_r   <= 2'd0;
            blink_r <= 1'b0;
            wrap_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            min_r   <= min_s;
            sec_r   <= sec_s;
            idx_r   <= idx_s;
            blink_r <= blink_s;
            wrap_r  <= wrap_s;
        end
    end

    // Scanned digit value selected from the registered count
    always_comb begin
        digit_val = 4'd0;
        case (idx_r)
            2'd0:    digit_val = sec_r[3:0];
            2'd1:    digit_val = sec_r[7:4];
            2'd2:    digit_val = min_r[3:0];
            2'd3:    digit_val = min_r[7:4];
            default: digit_val = 4'd0;
        endcase
    end

    // Blank the digits of the edited field during the off half of the blink
    always_comb begin
        digit_blank = 1'b0;
        if ((state_r == ADJUST) && blink_r) begin
            if (sw_sel) begin
                digit_blank = (idx_r < 2'd2);
            end else begin
                digit_blank = (idx_r >= 2'd2);
            end
        end else begin
            digit_blank = 1'b0;
        end
    end

    assign min_bcd   = min_r;
    assign sec_bcd   = sec_r;
    assign digit_idx = idx_r;
    assign running   = (state_r == RUN);
    assign wrap      = wrap_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: an integer reference model
// predicts every output after each driven cycle, the prediction is queued
// and then popped and compared once the DUT has clocked.
module tb_stopwatch_ctrl;

    localparam int MAXM = 59;

    logic       sclk = 1'b0;
    logic       rst_n;
    logic       tick_1hz, tick_2hz, tick_400hz;
    logic       btn_pause, btn_clr, sw_adj, sw_sel;
    logic [7:0] min_bcd, sec_bcd;
    logic [1:0] digit_idx;
    logic [3:0] digit_val;
    logic       digit_blank, running, wrap;

    typedef struct {
        string       tag;
        logic [24:0] v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state (0 = paused, 1 = run, 2 = adjust)
    int m_st, m_min, m_sec, m_idx, m_blink, m_wrap;

    stopwatch_ctrl #(.MAX_MIN(MAXM)) dut (
        .sclk(sclk), .rst_n(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .tick_400hz(tick_400hz), .btn_pause(btn_pause), .btn_clr(btn_clr),
        .sw_adj(sw_adj), .sw_sel(sw_sel), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .digit_idx(digit_idx), .digit_val(digit_val), .digit_blank(digit_blank),
        .running(running), .wrap(wrap)
    );

    // Free-running system clock
    always #5 sclk = ~sclk;

    // Time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic logic [24:0] obs_v();
        return {min_bcd, sec_bcd, running, wrap, digit_idx, digit_val, digit_blank};
    endfunction

    function automatic logic [24:0] mk();
        logic [3:0] dv;
        logic       blank;
        case (m_idx)
            0:       dv = 4'(m_sec % 10);
            1:       dv = 4'(m_sec / 10);
            2:       dv = 4'(m_min % 10);
            default: dv = 4'(m_min / 10);
        endcase
        blank = (m_st == 2) && (m_blink == 1) && (sw_sel ? (m_idx < 2) : (m_idx >= 2));
        return {to_bcd(m_min), to_bcd(m_sec), m_st == 1, m_wrap == 1, 2'(m_idx), dv, blank};
    endfunction

    task automatic model_reset();
        m_st = 0; m_min = 0; m_sec = 0; m_idx = 0; m_blink = 0; m_wrap = 0;
    endtask

    task automatic model_step(input bit t1, input bit t2, input bit t400, input bit bp, input bit bc);
        int nst;
        nst = m_st;
        if (m_st == 0) nst = sw_adj ? 2 : (bp ? 1 : 0);
        else if (m_st == 1) nst = sw_adj ? 2 : (bp ? 0 : 1);
        else nst = sw_adj ? 2 : 0;
        m_wrap = 0;
        if (bc) begin
            m_min = 0; m_sec = 0;
        end else if (m_st == 1 && t1) begin
            m_sec++;
            if (m_sec == 60) begin
                m_sec = 0; m_min++;
                if (m_min > MAXM) begin
                    m_min = 0; m_wrap = 1;
                end
            end
        end else if (m_st == 2 && t2) begin
            if (sw_sel) m_sec = (m_sec + 1) % 60;
            else m_min = (m_min + 1) % (MAXM + 1);
        end
        if (m_st == 2 && nst == 2) m_blink = t2 ? 1 - m_blink : m_blink;
        else m_blink = 0;
        if (t400) m_idx = (m_idx + 1) % 4;
        m_st = nst;
    endtask

    // Drive one cycle of pulses, queue the model's prediction, then clock
    task automatic drive(input string tag, input bit t1, input bit t2, input bit t400,
                         input bit bp, input bit bc);
        exp_t e;
        tick_1hz = t1; tick_2hz = t2; tick_400hz = t400; btn_pause = bp; btn_clr = bc;
        model_step(t1, t2, t400, bp, bc);
        e.tag = tag;
        e.v   = mk();
        sb.push_back(e);
        @(posedge sclk);
        #1;
        tick_1hz = 1'b0; tick_2hz = 1'b0; tick_400hz = 1'b0; btn_pause = 1'b0; btn_clr = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0; sw_adj = 1'b0; sw_sel = 1'b0;
        tick_1hz = 1'b0; tick_2hz = 1'b0; tick_400hz = 1'b0; btn_pause = 1'b0; btn_clr = 1'b0;
        #3;
        model_reset();
        e.tag = "reset"; e.v = mk(); sb.push_back(e);
        e = sb.pop_front(); n_cmp++;
        if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
        @(negedge sclk);
        rst_n = 1'b1;
        drive("reset_tick_ignored", 1, 1, 0, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
    endtask

    task automatic test_run_count();
        exp_t e;
        drive("start", 0, 0, 0, 1, 0);
        e = sb.pop_front(); n_cmp++;
        if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
        for (int i = 1; i <= 61; i++) begin
            drive("run_tick", 1, 0, (i % 3) == 0, 0, 0);
            e = sb.pop_front(); n_cmp++;
            if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s %0d: got %h required %h", e.tag, i, obs_v(), e.v); end
        end
        n_cmp++;
        if ({min_bcd, sec_bcd, running} !== {8'h01, 8'h01, 1'b1}) begin
            n_bad++; $display("FAIL count_61: got %h:%h run=%b required 01:01 run=1", min_bcd, sec_bcd, running);
        end
    endtask

    task automatic test_pause_ignore();
        exp_t e;
        drive("pause", 0, 0, 0, 1, 0);
        e = sb.pop_front(); n_cmp++;
        if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
        for (int i = 0; i < 3; i++) begin
            drive("paused_ticks", 1, 1, 0, 0, 0);
            e = sb.pop_front(); n_cmp++;
            if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
        end
    endtask

    task automatic test_adjust();
        exp_t e;
        drive("clr_paused", 0, 0, 0, 0, 1);
        e = sb.pop_front(); n_cmp++;
        if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
        sw_adj = 1'b1; sw_sel = 1'b1;
        drive("enter_adj", 1, 0, 0, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
        for (int i = 0; i < 61; i++) begin
            drive("adj_sec", 1, 1, i == 60, i == 5, 0);
            e = sb.pop_front(); n_cmp++;
            if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s %0d: got %h required %h", e.tag, i, obs_v(), e.v); end
        end
        n_cmp++;
        if ({min_bcd, sec_bcd, running} !== {8'h00, 8'h01, 1'b0}) begin
            n_bad++; $display("FAIL adj_58_plus3: got %h:%h run=%b required 00:01 run=0", min_bcd, sec_bcd, running);
        end
        sw_sel = 1'b0;
        drive("sel_change", 0, 0, 0, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
        for (int i = 0; i < MAXM + 1; i++) begin
            drive("adj_min", 0, 1, 1, 0, 0);
            e = sb.pop_front(); n_cmp++;
            if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s %0d: got %h required %h", e.tag, i, obs_v(), e.v); end
        end
        sw_adj = 1'b0;
        drive("leave_adj", 0, 0, 0, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
    endtask

    task automatic test_wrap();
        exp_t e;
        drive("clr", 0, 0, 0, 0, 1);
        void'(sb.pop_front());
        sw_adj = 1'b1; sw_sel = 1'b0;
        drive("enter_adj", 0, 0, 0, 0, 0);
        void'(sb.pop_front());
        for (int i = 0; i < MAXM; i++) begin drive("pre_min", 0, 1, 0, 0, 0); void'(sb.pop_front()); end
        sw_sel = 1'b1;
        for (int i = 0; i < 59; i++) begin drive("pre_sec", 0, 1, 0, 0, 0); void'(sb.pop_front()); end
        sw_adj = 1'b0;
        drive("to_paused", 0, 0, 0, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
        drive("to_run", 0, 0, 0, 1, 0);
        void'(sb.pop_front());
        drive("wrap_tick", 1, 0, 0, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
        n_cmp++;
        if ({min_bcd, sec_bcd, wrap} !== {8'h00, 8'h00, 1'b1}) begin
            n_bad++; $display("FAIL wrap_edge: got %h:%h wrap=%b required 00:00 wrap=1", min_bcd, sec_bcd, wrap);
        end
        drive("after_wrap", 0, 0, 0, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
    endtask

    task automatic test_clr_tick();
        exp_t e;
        drive("clr_run", 0, 0, 0, 0, 1);
        void'(sb.pop_front());
        for (int i = 0; i < 9; i++) begin drive("to_09", 1, 0, 0, 0, 0); void'(sb.pop_front()); end
        drive("clr_with_tick", 1, 0, 0, 0, 1);
        e = sb.pop_front(); n_cmp++;
        if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
        n_cmp++;
        if ({min_bcd, sec_bcd, running, wrap} !== {8'h00, 8'h00, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL clr_tick: got %h:%h run=%b wrap=%b required 00:00 run=1 wrap=0",
                              min_bcd, sec_bcd, running, wrap);
        end
        for (int i = 0; i < 3; i++) begin drive("to_03", 1, 0, 0, 0, 0); void'(sb.pop_front()); end
        drive("pause_with_tick", 1, 0, 0, 1, 0);
        e = sb.pop_front(); n_cmp++;
        if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
    endtask

    task automatic test_scan();
        exp_t e;
        logic [15:0] vals;
        logic [3:0]  blanks;
        drive("clr", 0, 0, 0, 0, 1);
        void'(sb.pop_front());
        sw_adj = 1'b1; sw_sel = 1'b0;
        drive("enter_adj", 0, 0, 0, 0, 0);
        void'(sb.pop_front());
        for (int i = 0; i < 12; i++) begin drive("set_min", 0, 1, 0, 0, 0); void'(sb.pop_front()); end
        sw_sel = 1'b1;
        for (int i = 0; i < 34; i++) begin drive("set_sec", 0, 1, 0, 0, 0); void'(sb.pop_front()); end
        sw_adj = 1'b0;
        drive("leave_adj", 0, 0, 0, 0, 0);
        void'(sb.pop_front());
        while (m_idx != 0) begin
            drive("align", 0, 0, 1, 0, 0);
            e = sb.pop_front(); n_cmp++;
            if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
        end
        vals = {12'h000, digit_val};
        for (int i = 0; i < 4; i++) begin
            drive("scan", 0, 0, 1, 0, 0);
            e = sb.pop_front(); n_cmp++;
            if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s %0d: got %h required %h", e.tag, i, obs_v(), e.v); end
            if (i < 3) vals = {vals[11:0], digit_val};
        end
        n_cmp++;
        if ({vals, digit_idx} !== {16'h4321, 2'd0}) begin
            n_bad++; $display("FAIL scan_seq: got %h idx=%0d required 4321 idx=0", vals, digit_idx);
        end
        sw_adj = 1'b1; sw_sel = 1'b0;
        drive("enter_adj2", 0, 0, 0, 0, 0);
        void'(sb.pop_front());
        drive("blink_on", 0, 1, 0, 0, 0);
        e = sb.pop_front(); n_cmp++;
        if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
        blanks = 4'b0000;
        blanks[digit_idx] = digit_blank;
        for (int i = 0; i < 3; i++) begin
            drive("blank_scan", 0, 0, 1, 0, 0);
            e = sb.pop_front(); n_cmp++;
            if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s %0d: got %h required %h", e.tag, i, obs_v(), e.v); end
            blanks[digit_idx] = digit_blank;
        end
        n_cmp++;
        if (blanks !== 4'b1100) begin
            n_bad++; $display("FAIL blank_pattern: got %b required 1100", blanks);
        end
        sw_adj = 1'b0;
        drive("leave_adj2", 0, 0, 0, 0, 0);
        void'(sb.pop_front());
    endtask

    task automatic test_reset_mid();
        exp_t e;
        drive("clr", 0, 0, 0, 0, 1);
        void'(sb.pop_front());
        sw_adj = 1'b1; sw_sel = 1'b0;
        drive("enter_adj", 0, 0, 0, 0, 0);
        void'(sb.pop_front());
        for (int i = 0; i < 3; i++) begin drive("set_min", 0, 1, 0, 0, 0); void'(sb.pop_front()); end
        sw_sel = 1'b1;
        for (int i = 0; i < 27; i++) begin drive("set_sec", 0, 1, 0, 0, 0); void'(sb.pop_front()); end
        sw_adj = 1'b0;
        drive("leave_adj", 0, 0, 1, 0, 0);
        void'(sb.pop_front());
        drive("run", 0, 0, 1, 1, 0);
        e = sb.pop_front(); n_cmp++;
        if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        e.tag = "async_reset"; e.v = mk(); sb.push_back(e);
        e = sb.pop_front(); n_cmp++;
        if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
        @(negedge sclk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive("post_reset", 1, 1, 0, 0, 0);
            e = sb.pop_front(); n_cmp++;
            if (obs_v() !== e.v) begin n_bad++; $display("FAIL %s: got %h required %h", e.tag, obs_v(), e.v); end
        end
    endtask

    // Scenario sequence and summary
    initial begin
        test_reset();
        test_run_count();
        test_pause_ignore();
        test_adjust();
        test_wrap();
        test_clr_tick();
        test_scan();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter MAX_MIN, default 59, the highest minute value before wrap (legal range 1..99).
REQ-002 SHALL have port sclk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have port tick_1hz, input, 1, a one-sclk-cycle count-enable pulse from the clock divider.
REQ-005 SHALL have port tick_2hz, input, 1, a one-cycle pulse that sets the adjust rate and blink rate.
REQ-006 SHALL have port tick_400hz, input, 1, a one-cycle pulse that sets the display scan rate.
REQ-007 SHALL have port btn_pause, input, 1, a debounced one-cycle pulse that toggles run/pause.
REQ-008 SHALL have port btn_clr, input, 1, a debounced one-cycle pulse that clears the count.
REQ-009 SHALL have port sw_adj, input, 1, a level that requests adjust mode.
REQ-010 SHALL have port sw_sel, input, 1, a level that selects the adjust field: 0 = minutes, 1 = seconds.
REQ-011 SHALL have port min_bcd, output, 8, the minutes as two BCD digits {tens, ones}.
REQ-012 SHALL have port sec_bcd, output, 8, the seconds as two BCD digits {tens, ones}.
REQ-013 SHALL have port digit_idx, output, 2, the scanned digit: 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens.
REQ-014 SHALL have port digit_val, output, 4, the BCD value of the digit selected by digit_idx.
REQ-015 SHALL have port digit_blank, output, 1, which is 1 when the scanned digit is to be blanked (adjust blink).
REQ-016 SHALL have port running, output, 1, which is 1 in state RUN.
REQ-017 SHALL have port wrap, output, 1, a one-cycle pulse when the count rolls over from MAX_MIN:59 to 00:00 in RUN.

Function
REQ-018 SHALL implement the FSM states PAUSED, RUN and ADJUST, and SHALL enter PAUSED on reset.
REQ-019 SHALL use the following transition priority each cycle: sw_adj=1, then btn_pause; btn_clr is orthogonal and does not change state.
- PAUSED: sw_adj=1 -> ADJUST; otherwise btn_pause -> RUN.
- RUN: sw_adj=1 -> ADJUST; otherwise btn_pause -> PAUSED.
- ADJUST: sw_adj=0 -> PAUSED; btn_pause is ignored.
REQ-020 SHALL, in RUN on tick_1hz, increment seconds; at 59 seconds SHALL set seconds to 00 and carry into minutes; minutes at MAX_MIN with seconds at 59 SHALL go to 00:00 and assert wrap on the same edge.
REQ-021 SHALL, in ADJUST on tick_2hz, increment only the selected field, wrapping seconds 59->00 and minutes MAX_MIN->00, with no carry and no wrap pulse.
REQ-022 SHALL ignore tick_1hz in PAUSED and ADJUST, and SHALL ignore tick_2hz outside ADJUST for counting.
REQ-023 SHALL, on btn_clr in any state, set the count to 00:00 on that edge; btn_clr SHALL take priority over a same-cycle tick increment, and wrap SHALL not assert.
REQ-024 SHALL, when btn_pause and tick_1hz coincide in RUN, apply the increment and enter PAUSED on the same edge.
REQ-025 SHALL keep the BCD digits legal at all times: ones 0..9, seconds tens 0..5, minutes tens 0..MAX_MIN/10.
REQ-026 SHALL advance digit_idx by 1 (mod 4) on each tick_400hz, with digit_val a combinational mux of the registered count by digit_idx.
REQ-027 SHALL toggle an internal blink phase on each tick_2hz in ADJUST, and SHALL hold blink phase 0 outside ADJUST.
REQ-028 SHALL assert digit_blank only when in ADJUST, blink phase = 1, and digit_idx lies in the field selected by sw_sel.
REQ-029 SHALL, when sw_sel changes mid-ADJUST, apply the new field from the next tick_2hz with no count change.

Reset
REQ-030 SHALL, on rst_n=0, asynchronously force state PAUSED, count 00:00, digit_idx 0, blink phase 0, running 0, wrap 0 and digit_blank 0.
REQ-031 SHALL, after rst_n deasserts mid-operation, resume from PAUSED with no spurious wrap, and SHALL act on no tick arriving in the deassertion cycle's state.

Verification
REQ-032 SHALL be verified by: reset, btn_pause, 61 tick_1hz -> min_bcd=8'h01, sec_bcd=8'h01, running=1.
REQ-033 SHALL be verified by: preload 59:59 in RUN, tick_1hz -> 00:00 and wrap high for exactly one cycle.
REQ-034 SHALL be verified by: sw_adj=1 with sw_sel=1 at 00:58, three tick_2hz -> sec_bcd=8'h01, min_bcd=8'h00, running=0.
REQ-035 SHALL be verified by: btn_clr coincident with tick_1hz at 00:09 in RUN -> 00:00, state stays RUN, wrap=0.
REQ-036 SHALL be verified by: four tick_400hz at 12:34 -> digit_val sequence 4,3,2,1 and digit_idx back to 0; in ADJUST with sw_sel=0 and blink phase 1 -> digit_blank=1 only at idx 2 and 3.
REQ-037 SHALL be verified by: rst_n low mid-RUN at 03:27 -> all outputs at reset values immediately, without waiting for an sclk edge.
